// File: rtl/unidade_busca_cp.sv
// Instruction fetch / program-counter unit.
// Fetches 16-bit words over a req/ack handshake into the IR, exposes the
// opcode to the control unit and updates the PC from EscCP/EscCondCP/FonteCP.
module unidade_busca_cp #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            EscCP,
    input  logic            EscCondCP,
    input  logic [1:0]      FonteCP,
    input  logic            zero,
    input  logic [PC_W-1:0] ula_result,
    input  logic [15:0]     mem_rdata,
    input  logic            mem_ack,
    output logic            mem_req,
    output logic [PC_W-1:0] mem_addr,
    output logic [3:0]      opcode,
    output logic [15:0]     instr,
    output logic [PC_W-1:0] pc,
    output logic            instr_valid,
    output logic            halted
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    state_t          state_q, state_n;
    logic [PC_W-1:0] pc_q, pc_n;
    logic [15:0]     ir_q, ir_n;
    logic            req_q, req_n;
    logic            valid_q, valid_n;

    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] br_off;
    logic [PC_W-1:0] jmp_tgt;
    logic [PC_W-1:0] pc_src;
    logic [PC_W-1:0] pc_upd;

    assign pc_inc  = pc_q + PC_W'(1);
    assign br_off  = PC_W'($signed(ir_q[7:0]));
    assign jmp_tgt = PC_W'(ir_q[11:0]);

    // PC source mux and EscCP/EscCondCP/zero write rule applied in EXEC
    always_comb begin
        pc_src = pc_inc;
        unique case (FonteCP)
            2'b00: pc_src = pc_inc;
            2'b01: pc_src = pc_inc + br_off;
            2'b10: pc_src = jmp_tgt;
            2'b11: pc_src = ula_result;
            default: pc_src = pc_inc;
        endcase

        pc_upd = pc_q;
        if (EscCP) begin
            if (EscCondCP && !zero) begin
                pc_upd = pc_inc;
            end else begin
                pc_upd = pc_src;
            end
        end
    end

    // Next-state logic for the fetch/decode/exec/halt sequence
    always_comb begin
        state_n = state_q;
        pc_n    = pc_q;
        ir_n    = ir_q;
        req_n   = req_q;
        valid_n = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                if (req_q && mem_ack) begin
                    ir_n    = mem_rdata;
                    req_n   = 1'b0;
                    valid_n = 1'b1;
                    state_n = S_DECODE;
                end else begin
                    req_n = 1'b1;
                end
            end
            S_DECODE: begin
                req_n   = 1'b0;
                state_n = (ir_q[15:12] == 4'hF) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                // Request is raised on the same edge as the PC update, so
                // mem_addr and mem_req change together and a zero-wait
                // fetch loop repeats every three cycles.
                pc_n    = pc_upd;
                req_n   = 1'b1;
                state_n = S_FETCH;
            end
            S_HALT: begin
                req_n = 1'b0;
            end
            default: begin
                req_n   = 1'b0;
                state_n = S_FETCH;
            end
        endcase
    end

    // State, PC, IR and handshake registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            ir_q    <= ir_n;
            req_q   <= req_n;
            valid_q <= valid_n;
        end
    end

    assign mem_req     = req_q;
    assign mem_addr    = pc_q;
    assign pc          = pc_q;
    assign instr       = ir_q;
    assign opcode      = ir_q[15:12];
    assign instr_valid = valid_q;
    assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_unidade_busca_cp.sv
// Scoreboard bench for unidade_busca_cp: the bench plays memory and control
// unit, predicts fetch addresses and IR contents with a simple PC model.
module tb_unidade_busca_cp;

    localparam int PC_W = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            EscCP, EscCondCP, zero;
    logic [1:0]      FonteCP;
    logic [PC_W-1:0] ula_result;
    logic [15:0]     mem_rdata;
    logic            mem_ack;
    logic            mem_req;
    logic [PC_W-1:0] mem_addr;
    logic [3:0]      opcode;
    logic [15:0]     instr;
    logic [PC_W-1:0] pc;
    logic            instr_valid;
    logic            halted;

    unidade_busca_cp #(.PC_W(PC_W), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .EscCP(EscCP), .EscCondCP(EscCondCP),
        .FonteCP(FonteCP), .zero(zero), .ula_result(ula_result),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_req(mem_req),
        .mem_addr(mem_addr), .opcode(opcode), .instr(instr), .pc(pc),
        .instr_valid(instr_valid), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       esc;
        bit       cond;
        bit [1:0] fonte;
        bit       z;
        bit [7:0] ula;
    } ctrl_t;

    logic [15:0] mem [256];
    ctrl_t       dir_q[$];
    int          exp_addr[$];
    logic [15:0] exp_instr[$];

    int          tests = 0;
    int          fails = 0;
    int          model_pc;
    int          instr_cnt;
    int          wait_cnt = 0;
    bit          chk_en = 0;
    bit          resp_en = 1;
    bit          expect_halt = 0;
    bit          prev_acc = 0;
    logic [15:0] last_instr = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic flag_fail(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: got event/timeout expected none at %0t", nm, $time);
    endtask

    // Reference PC rule: plain modulo-256 arithmetic on integers
    function automatic int nxt_pc(input int p, input logic [15:0] ins, input ctrl_t c);
        int p1, off, src;
        p1  = (p + 1) % 256;
        off = int'(ins[7:0]);
        if (off >= 128) off = off - 256;
        case (c.fonte)
            2'd0:    src = p1;
            2'd1:    src = (p1 + off) & 255;
            2'd2:    src = int'(ins[11:0]) & 255;
            default: src = int'(c.ula);
        endcase
        if (!c.esc) return p;
        if (c.cond && !c.z) return p1;
        return src;
    endfunction

    function automatic ctrl_t mk(input bit e, input bit cnd, input bit [1:0] f,
                                 input bit z, input bit [7:0] u);
        ctrl_t c;
        c.esc = e; c.cond = cnd; c.fonte = f; c.z = z; c.ula = u;
        return c;
    endfunction

    // Memory responder: random wait states, spurious acks while idle
    always @(posedge clk) begin
        #1;
        if (resp_en) begin
            if (mem_req) begin
                if (wait_cnt == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr];
                end else begin
                    wait_cnt--;
                    mem_ack   = 1'b0;
                    mem_rdata = 16'($urandom);
                end
            end else begin
                mem_ack   = ($urandom % 3 == 0);
                mem_rdata = 16'($urandom);
                wait_cnt  = ($urandom % 4 == 0) ? 4 : int'($urandom % 3);
            end
        end
    end

    // Control-unit stimulus: on each new instruction choose controls and predict the next fetch
    always @(posedge clk) begin
        ctrl_t       c;
        logic [15:0] ins;
        #1;
        if (chk_en && rst_n && instr_valid) begin
            ins = mem[model_pc];
            if (ins[15:12] == 4'hF) begin
                expect_halt = 1;
            end else begin
                if (dir_q.size() > 0) c = dir_q.pop_front();
                else c = mk(($urandom % 5) != 0, 1'($urandom), 2'($urandom),
                            1'($urandom), 8'($urandom));
                EscCP      = c.esc;
                EscCondCP  = c.cond;
                FonteCP    = c.fonte;
                zero       = c.z;
                ula_result = c.ula;
                model_pc   = nxt_pc(model_pc, ins, c);
                exp_addr.push_back(model_pc);
                instr_cnt++;
            end
        end
    end

    // Monitor: pops expectations when the DUT accepts a fetch or loads the IR
    always @(negedge clk) begin
        bit acc;
        int a;
        logic [15:0] e;
        if (chk_en && rst_n) begin
            acc = mem_req && mem_ack;
            chk("instr_valid", instr_valid, prev_acc);
            if (instr_valid) begin
                if (exp_instr.size() == 0) flag_fail("ir_load_unexpected");
                else begin
                    e = exp_instr.pop_front();
                    chk("instr", instr, e);
                    chk("opcode", opcode, e[15:12]);
                    last_instr = e;
                end
            end else begin
                chk("ir_hold", instr, last_instr);
            end
            if (!expect_halt) chk("halted_low", halted, 0);
            if (acc) begin
                if (exp_addr.size() == 0) flag_fail("fetch_unexpected");
                else begin
                    a = exp_addr.pop_front();
                    chk("mem_addr", mem_addr, a);
                    chk("pc", pc, a);
                    exp_instr.push_back(mem[a]);
                end
            end
            prev_acc = acc;
        end else begin
            prev_acc = 0;
        end
    end

    task automatic do_reset;
        chk_en = 0;
        @(negedge clk);
        rst_n = 0;
        exp_addr.delete();
        exp_instr.delete();
        model_pc    = 0;
        exp_addr.push_back(0);
        last_instr  = '0;
        expect_halt = 0;
        instr_cnt   = 0;
        @(negedge clk);
        rst_n  = 1;
        chk_en = 1;
    endtask

    initial begin
        bit found;
        rst_n = 0; EscCP = 0; EscCondCP = 0; FonteCP = 0; zero = 0;
        ula_result = '0; mem_ack = 0; mem_rdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_pc", pc, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_instr", instr, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_halted", halted, 0);

        // Directed program: jump, branch taken/not taken, ULA source, stall, wrap, halt
        mem[8'h00] = 16'hB010;
        mem[8'h10] = 16'hC0FE;
        mem[8'h0F] = 16'h0000;
        mem[8'h11] = 16'hB0A5;
        mem[8'hA5] = 16'h1234;
        mem[8'h3C] = 16'h2000;
        mem[8'hFF] = 16'h3000;
        mem[8'h40] = 16'hF000;
        dir_q.push_back(mk(1, 0, 2'd2, 0, 8'h00));  // 00 -> 10
        dir_q.push_back(mk(1, 1, 2'd1, 1, 8'h00));  // 10 -> 0F taken
        dir_q.push_back(mk(1, 0, 2'd0, 0, 8'h00));  // 0F -> 10
        dir_q.push_back(mk(1, 1, 2'd1, 0, 8'h00));  // 10 -> 11 not taken
        dir_q.push_back(mk(1, 0, 2'd2, 0, 8'h00));  // 11 -> A5
        dir_q.push_back(mk(1, 0, 2'd3, 0, 8'h3C));  // A5 -> 3C
        dir_q.push_back(mk(0, 1, 2'd3, 1, 8'h77));  // 3C stall
        dir_q.push_back(mk(1, 0, 2'd3, 0, 8'hFF));  // 3C -> FF
        dir_q.push_back(mk(1, 0, 2'd0, 0, 8'h00));  // FF -> 00 wrap
        dir_q.push_back(mk(1, 0, 2'd3, 0, 8'h40));  // 00 -> 40
        do_reset();
        @(posedge clk);
        #1;
        chk("first_req", mem_req, 1);

        for (int i = 0; i < 500 && !expect_halt; i++) @(negedge clk);
        if (!expect_halt) flag_fail("halt_timeout");
        else begin
            chk("dir_consumed", dir_q.size(), 0);
            @(negedge clk);
            for (int i = 0; i < 20; i++) begin
                chk("halted", halted, 1);
                chk("halt_mem_req", mem_req, 0);
                chk("halt_pc", pc, 8'h40);
                chk("halt_instr", instr, 16'hF000);
                @(negedge clk);
            end
        end

        // Random program without HALT opcodes
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'($urandom);
            mem[i][15:12] = 4'($urandom % 15);
        end
        do_reset();
        for (int i = 0; i < 6000 && instr_cnt < 200; i++) @(negedge clk);
        if (instr_cnt < 200) flag_fail("random_timeout");

        // Asynchronous reset while a fetch is being acknowledged
        chk_en  = 0;
        resp_en = 0;
        found   = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (mem_req) found = 1;
        end
        if (!found) flag_fail("async_no_fetch");
        else begin
            mem_ack   = 1'b1;
            mem_rdata = 16'hFFFF;
            #1 rst_n = 0;
            #1;
            chk("async_mem_req", mem_req, 0);
            chk("async_pc", pc, 0);
            chk("async_mem_addr", mem_addr, 0);
            chk("async_instr", instr, 0);
            chk("async_instr_valid", instr_valid, 0);
            @(posedge clk);
            #1;
            chk("async_ack_discarded", instr, 0);
            chk("async_req_held", mem_req, 0);
            mem_ack = 1'b0;
            @(negedge clk);
            rst_n = 1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/unidade_busca_cp.md
Name: unidade_busca_cp

Overview:
- Instruction fetch and program-counter unit; the consumer end of the control-unit interface.
- Fetches 16-bit instructions from instruction memory over a req/ack handshake and holds them in the instruction register (IR).
- Presents the opcode to the control unit, then applies the control unit's EscCP/EscCondCP/FonteCP decisions to update the PC.
- Sits between instruction memory, the control unit and the ULA zero/result outputs.

Parameters:
PC_W, 8, program counter and memory address width in bits
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
EscCP  input  1  PC write enable from control unit
EscCondCP  input  1  conditional (branch) PC write from control unit
FonteCP  input  2  PC source select from control unit
zero  input  1  ULA zero flag
ula_result  input  PC_W  ULA result, used as PC source 11
mem_rdata  input  16  instruction word from memory
mem_ack  input  1  memory data valid, qualifies mem_rdata
mem_req  output  1  fetch request, registered
mem_addr  output  PC_W  fetch address, equal to pc
opcode  output  4  IR[15:12] to control unit
instr  output  16  full IR contents
pc  output  PC_W  current program counter
instr_valid  output  1  one-cycle pulse when IR is newly loaded
halted  output  1  high in HALT state

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH, pc=RESET_PC.
  - instr=16'h0000, so opcode=0.
  - mem_req=0, instr_valid=0, halted=0.
  - All outputs take effect immediately, without waiting for a clock edge.
- First rising edge after rst_n deasserts: mem_req=1 with mem_addr=pc.
- FSM states: FETCH, DECODE, EXEC, HALT.
- FETCH:
  - Hold mem_req=1 until a cycle in which mem_ack=1.
  - On that edge: IR<=mem_rdata, mem_req<=0, instr_valid<=1 for exactly one cycle, state<=DECODE.
  - mem_ack while mem_req=0 is ignored.
  - mem_rdata is ignored unless mem_ack=1.
- DECODE:
  - One cycle. The control unit registers its outputs from opcode during this cycle.
  - If opcode==4'hF: state<=HALT. Otherwise state<=EXEC.
- EXEC:
  - Sample EscCP, EscCondCP, FonteCP and zero; update the PC; state<=FETCH.
  - The next fetch request begins on the following edge.
- PC source by FonteCP, all arithmetic modulo 2^PC_W:
  - 00: pc+1.
  - 01: pc+1+sign-extended IR[7:0], truncated to PC_W.
  - 10: zero-extended IR[11:0], truncated to PC_W.
  - 11: ula_result.
- PC update rule in EXEC:
  - EscCP=0: pc holds (stall). The same instruction is re-fetched.
  - EscCP=1, EscCondCP=0: pc<=selected source.
  - EscCP=1, EscCondCP=1, zero=1: pc<=selected source (branch taken).
  - EscCP=1, EscCondCP=1, zero=0: pc<=pc+1 (branch not taken).
  - EscCondCP=1 with EscCP=0: treated as a stall.
- Wrap-around: pc+1 at pc=2^PC_W-1 yields 0. Branch offsets wrap the same way.
- IR and opcode change only on an accepted fetch.
- HALT:
  - mem_req=0, halted=1; pc and IR frozen.
  - Left only by reset.
- Reset mid-fetch: mem_req drops asynchronously. A pending mem_ack in the same cycle is discarded.
- Latency: a fetch with zero memory wait takes 3 cycles: FETCH edge, DECODE, EXEC. Each wait cycle on mem_ack adds one.

Test Plan:
- Reset then sequential fetch: memory acks immediately with opcode 0 words and control gives EscCP=1, FonteCP=00 -> mem_addr sequence 0,1,2,3; one instr_valid pulse every 3 cycles.
- Wait states: mem_ack delayed 4 cycles -> mem_req held high throughout; IR unchanged until the ack edge; exactly one instr_valid pulse.
- Branch: pc=0x10, IR=0xC0FE, EscCP=1, EscCondCP=1, FonteCP=01.
  - zero=1 -> pc=0x0F.
  - zero=0 -> pc=0x11.
- Jump, ULA source and wrap:
  - IR=0xB0A5, FonteCP=10 -> pc=0xA5.
  - FonteCP=11, ula_result=0x3C -> pc=0x3C.
  - pc=0xFF, FonteCP=00 -> pc=0x00.
- Stall and halt:
  - EscCP=0 in EXEC -> same mem_addr re-fetched.
  - Opcode 0xF -> halted=1, mem_req stays 0 for 20 cycles.
- Async reset: assert rst_n=0 mid-FETCH with mem_ack=1 in the same cycle -> mem_req=0 and pc=RESET_PC with no clock edge; IR=0.
